// File: rtl/phy_pkg.sv
// Shared PHY symbol definitions and receive-sync state encoding.
package phy_pkg;

  // Line symbols, shared with the transmit side.
  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLE  = 8'h7C;

  // Word-lock state of the receive sync controller.
  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } sync_state_e;

endpackage

// File: rtl/phy_rx_sync_ctrl.sv
// Receive word-lock controller: acquires lock on consecutive commas, then
// steers each data byte to a demux lane and realigns the lane pointer on commas.
module phy_rx_sync_ctrl
  import phy_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_GAP    = 64
) (
  input  logic                         clk_4f,
  input  logic                         reset,
  input  logic [7:0]                   data_in,
  input  logic                         valid_in,
  output logic                         active,
  output logic [7:0]                   data_out,
  output logic [$clog2(NUM_LANES)-1:0] lane_sel,
  output logic                         valid_out,
  output logic                         lock_loss
);

  localparam int unsigned LANE_W  = $clog2(NUM_LANES);
  localparam int unsigned COMMA_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned GAP_W   = $clog2(MAX_GAP + 1) + 1;

  // The comma that brings comma_cnt up to LOCK_COUNT is the one seen at LOCK_COUNT-1.
  localparam logic [COMMA_W-1:0] COMMA_LAST = COMMA_W'(LOCK_COUNT - 1);
  localparam logic [GAP_W-1:0]   GAP_LIMIT  = GAP_W'(MAX_GAP);

  sync_state_e        state_q, state_d;
  logic [COMMA_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [LANE_W-1:0]  lane_ptr_q, lane_ptr_d;

  logic is_comma;
  logic is_idle;
  logic fwd;
  logic loss;

  assign is_comma = (data_in == COMMA);
  assign is_idle  = (data_in == IDLE);

  // Next-state, counter and forwarding decisions for the sampled word.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    lane_ptr_d  = lane_ptr_q;
    fwd         = 1'b0;
    loss        = 1'b0;

    if (valid_in) begin
      unique case (state_q)
        SEARCH: begin
          if (is_comma) begin
            if (comma_cnt_q == COMMA_LAST) begin
              state_d     = LOCKED;
              comma_cnt_d = '0;
              gap_cnt_d   = '0;
              lane_ptr_d  = '0;
            end else begin
              comma_cnt_d = comma_cnt_q + COMMA_W'(1);
            end
          end else begin
            comma_cnt_d = '0;
          end
        end

        LOCKED: begin
          if (is_comma) begin
            // A comma always wins, even on the word that would overflow the gap.
            gap_cnt_d  = '0;
            lane_ptr_d = '0;
          end else if (gap_cnt_q >= GAP_LIMIT) begin
            // Too long without a comma: drop lock and discard this word.
            state_d     = SEARCH;
            loss        = 1'b1;
            comma_cnt_d = '0;
            gap_cnt_d   = '0;
            lane_ptr_d  = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
            if (!is_idle) begin
              fwd        = 1'b1;
              lane_ptr_d = lane_ptr_q + LANE_W'(1);
            end
          end
        end

        default: state_d = SEARCH;
      endcase
    end
  end

  // State and counter registers; held whenever valid_in is low.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      comma_cnt_q <= '0;
      gap_cnt_q   <= '0;
      lane_ptr_q  <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      lane_ptr_q  <= lane_ptr_d;
    end
  end

  // Output register: forwarded byte, its lane, and the one-cycle strobes.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      data_out  <= 8'h00;
      lane_sel  <= '0;
      valid_out <= 1'b0;
      lock_loss <= 1'b0;
    end else begin
      valid_out <= fwd;
      lock_loss <= loss;
      if (fwd) begin
        data_out <= data_in;
        lane_sel <= lane_ptr_q;
      end
    end
  end

  assign active = (state_q == LOCKED);

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Self-checking bench for phy_rx_sync_ctrl: behavioural model plus directed and random stimulus.
module tb_phy_rx_sync_ctrl;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned LOCK_COUNT = 4;
  localparam int unsigned MAX_GAP    = 64;

  logic       clk_4f   = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       active;
  logic [7:0] data_out;
  logic [1:0] lane_sel;
  logic       valid_out;
  logic       lock_loss;

  phy_rx_sync_ctrl #(
    .NUM_LANES (NUM_LANES),
    .LOCK_COUNT(LOCK_COUNT),
    .MAX_GAP   (MAX_GAP)
  ) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .active   (active),
    .data_out (data_out),
    .lane_sel (lane_sel),
    .valid_out(valid_out),
    .lock_loss(lock_loss)
  );

  always #5 clk_4f = ~clk_4f;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: lock flag, consecutive commas seen, words since last comma, next lane.
  bit m_locked = 1'b0;
  int m_commas = 0;
  int m_gap    = 0;
  int m_lane   = 0;
  // Expected registered outputs for the current cycle.
  bit e_valid  = 1'b0;
  bit e_loss   = 1'b0;
  int e_data   = 0;
  int e_lane   = 0;

  logic [15:0] fwd_log[$];
  int          loss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, evaluated on every clock edge and on reset assertion.
  initial begin
    forever begin
      @(posedge clk_4f or posedge reset);
      if (reset) begin
        m_locked = 1'b0;
        m_commas = 0;
        m_gap    = 0;
        m_lane   = 0;
        e_valid  = 1'b0;
        e_loss   = 1'b0;
        e_data   = 0;
        e_lane   = 0;
      end else begin
        e_valid = 1'b0;
        e_loss  = 1'b0;
        if (valid_in) begin
          if (!m_locked) begin
            if (data_in == 8'hBC) begin
              m_commas++;
              if (m_commas == LOCK_COUNT) begin
                m_locked = 1'b1;
                m_commas = 0;
                m_gap    = 0;
                m_lane   = 0;
              end
            end else begin
              m_commas = 0;
            end
          end else if (data_in == 8'hBC) begin
            m_lane = 0;
            m_gap  = 0;
          end else if (m_gap + 1 > MAX_GAP) begin
            m_locked = 1'b0;
            e_loss   = 1'b1;
            m_commas = 0;
            m_gap    = 0;
            m_lane   = 0;
          end else begin
            m_gap++;
            if (data_in != 8'h7C) begin
              e_valid = 1'b1;
              e_data  = data_in;
              e_lane  = m_lane;
              m_lane  = (m_lane + 1) % NUM_LANES;
            end
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk_4f) begin
    check("active", 32'(active), 32'(m_locked));
    check("valid_out", 32'(valid_out), 32'(e_valid));
    check("lock_loss", 32'(lock_loss), 32'(e_loss));
    if (e_valid) begin
      check("data_out", 32'(data_out), 32'(e_data));
      check("lane_sel", 32'(lane_sel), 32'(e_lane));
    end
    if (valid_out === 1'b1) fwd_log.push_back({6'b0, lane_sel, data_out});
    if (lock_loss === 1'b1) loss_cnt++;
  end

  // Drive one word just after a falling edge; on return, outputs reflect the previous word.
  task automatic send(input bit v, input logic [7:0] d);
    @(negedge clk_4f);
    #1;
    valid_in = v;
    data_in  = d;
  endtask

  task automatic sync_reset();
    @(negedge clk_4f);
    #1;
    reset    = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk_4f);
    #1;
    reset = 1'b0;
  endtask

  // Assert reset between edges and confirm the outputs drop without a clock.
  task automatic async_reset(input bit check_now);
    @(posedge clk_4f);
    #2;
    reset = 1'b1;
    #1;
    if (check_now) begin
      check("async_active", 32'(active), 32'd0);
      check("async_valid_out", 32'(valid_out), 32'd0);
    end
    @(negedge clk_4f);
    #1;
    reset    = 1'b0;
    valid_in = 1'b0;
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hBC) b = 8'h00;
    return b;
  endfunction

  initial begin
    logic [7:0] d;
    bit         v;
    int         r;
    int         bc_pct;
    int         nonidle;
    int         loss0;
    logic [15:0] exp5[3];
    int          exp_lane4[6];

    exp5      = '{16'h0011, 16'h0122, 16'h0033};
    exp_lane4 = '{0, 1, 2, 3, 0, 1};

    // Reset values.
    repeat (3) @(negedge clk_4f);
    #1;
    check("reset_active", 32'(active), 32'd0);
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_lane_sel", 32'(lane_sel), 32'd0);
    check("reset_lock_loss", 32'(lock_loss), 32'd0);
    reset = 1'b0;

    // Four commas lock on the cycle after the fourth.
    fwd_log.delete();
    repeat (3) send(1'b1, 8'hBC);
    send(1'b1, 8'hBC);
    check("not_locked_after_3", 32'(active), 32'd0);
    send(1'b0, 8'h00);
    check("locked_after_4", 32'(active), 32'd1);
    check("no_fwd_during_lock", 32'(fwd_log.size()), 32'd0);

    // A non-comma breaks the comma run.
    sync_reset();
    repeat (3) send(1'b1, 8'hBC);
    send(1'b1, 8'h55);
    repeat (4) send(1'b1, 8'hBC);
    check("broken_run_not_locked", 32'(active), 32'd0);
    send(1'b0, 8'h00);
    check("broken_run_relocked", 32'(active), 32'd1);

    // Back-to-back data rotates through the lanes.
    fwd_log.delete();
    for (int i = 1; i <= 6; i++) send(1'b1, 8'(i));
    send(1'b0, 8'h00);
    check("b2b_count", 32'(fwd_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < fwd_log.size()) begin
        check("b2b_lane", 32'(fwd_log[i][15:8]), 32'(exp_lane4[i]));
        check("b2b_data", 32'(fwd_log[i][7:0]), 32'(i + 1));
      end
    end

    // Idle holds the pointer; comma realigns it.
    send(1'b1, 8'hBC);
    send(1'b0, 8'h00);
    fwd_log.delete();
    send(1'b1, 8'h11);
    send(1'b1, 8'h7C);
    send(1'b1, 8'h22);
    send(1'b1, 8'hBC);
    send(1'b1, 8'h33);
    send(1'b0, 8'h00);
    check("idle_comma_count", 32'(fwd_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < fwd_log.size()) check("idle_comma_entry", 32'(fwd_log[i]), 32'(exp5[i]));
    end

    // MAX_GAP+1 words without a comma lose lock; the last word is dropped.
    send(1'b1, 8'hBC);
    send(1'b0, 8'h00);
    fwd_log.delete();
    loss0   = loss_cnt;
    nonidle = 0;
    for (int i = 0; i <= MAX_GAP; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 8'h7C : rand_data();
      if (i < MAX_GAP && d != 8'h7C) nonidle++;
      send(1'b1, d);
    end
    send(1'b0, 8'h00);
    check("gap_loss_pulses", 32'(loss_cnt - loss0), 32'd1);
    check("gap_active_dropped", 32'(active), 32'd0);
    check("gap_fwd_count", 32'(fwd_log.size()), 32'(nonidle));
    repeat (4) send(1'b1, 8'hBC);
    send(1'b0, 8'h00);
    check("gap_relocked", 32'(active), 32'd1);

    // valid_in gaps do not advance the pointer; async reset mid-stream.
    fwd_log.delete();
    send(1'b1, 8'hA1);
    send(1'b0, 8'hBC);
    send(1'b1, 8'hA2);
    send(1'b0, 8'h7C);
    send(1'b1, 8'hA3);
    send(1'b0, 8'h00);
    check("gap_valid_count", 32'(fwd_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < fwd_log.size()) check("gap_valid_lane", 32'(fwd_log[i][15:8]), 32'(i));
    end
    send(1'b1, 8'hA4);
    async_reset(1'b1);
    fwd_log.delete();
    for (int i = 0; i < 20; i++) send(1'b1, rand_data());
    send(1'b0, 8'h00);
    check("post_reset_no_fwd", 32'(fwd_log.size()), 32'd0);
    check("post_reset_inactive", 32'(active), 32'd0);

    // Randomized traffic with varying comma density and occasional resets.
    for (int seg = 0; seg < 12; seg++) begin
      bc_pct = (seg % 3 == 0) ? 40 : ((seg % 3 == 1) ? 6 : 0);
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 599) == 0) async_reset(1'b0);
        v = ($urandom_range(0, 99) < 80);
        r = $urandom_range(0, 99);
        if (r < bc_pct) d = 8'hBC;
        else if (r < bc_pct + 10) d = 8'h7C;
        else d = rand_data();
        send(v, d);
      end
    end
    send(1'b0, 8'h00);
    @(negedge clk_4f);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phy_rx_sync_ctrl.md
Name: phy_rx_sync_ctrl

Overview:
Byte-rate controller for the PHY receive path. It sits between the serial-to-parallel converter and the 4-lane demux, and runs entirely on clk_4f. It acquires word lock by counting comma symbols and holds that lock while the link is healthy. Once locked, it steers each received byte to a lane with a per-byte valid strobe, and it realigns the lane pointer on every comma.

Parameters:
COMMA, 8'hBC, alignment/sync symbol
IDLE, 8'h7C, idle filler symbol; never forwarded as data
NUM_LANES, 4, number of demux lanes (power of 2)
LOCK_COUNT, 4, consecutive valid COMMA words required to lock
MAX_GAP, 64, max valid words between commas while locked before declaring loss of lock

Ports:
clk_4f  input  1  byte-rate clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  8  parallel byte from serial-to-parallel stage
valid_in  input  1  data_in qualifier; when low the block holds all state
active  output  1  high while in LOCKED
data_out  output  8  registered copy of forwarded byte
lane_sel  output  $clog2(NUM_LANES)  destination lane of data_out
valid_out  output  1  one-cycle strobe: data_out/lane_sel meaningful
lock_loss  output  1  one-cycle pulse on LOCKED->SEARCH transition

Behaviour:
- Reset (async assert, sync release):
  - state=SEARCH; active=0, valid_out=0, lock_loss=0.
  - data_out=8'h00, lane_sel=0.
  - comma_cnt=0, gap_cnt=0, lane_ptr=0.
- Outputs are registered. Latency is 1 cycle from the valid_in sample to valid_out/data_out.
- valid_in=0: no state, counter or pointer change; valid_out=0 next cycle.
- SEARCH (active=0, valid_out always 0):
  - valid COMMA: comma_cnt+1. When comma_cnt reaches LOCK_COUNT, go to LOCKED. active=1 from the next cycle. Set lane_ptr=0, gap_cnt=0, comma_cnt=0.
  - Any other valid word: comma_cnt=0.
- LOCKED (active=1):
  - valid COMMA: lane_ptr=0, gap_cnt=0, valid_out=0. Not forwarded.
  - valid IDLE: valid_out=0, lane_ptr unchanged, gap_cnt+1.
  - valid other byte: data_out=data_in, lane_sel=lane_ptr, valid_out=1. lane_ptr=(lane_ptr+1) mod NUM_LANES, wrapping 3->0. gap_cnt+1.
  - If gap_cnt would exceed MAX_GAP on a non-comma word:
    - go to SEARCH; that word is not forwarded (valid_out=0).
    - active=0 and lock_loss=1 for one cycle; comma_cnt=0, lane_ptr=0.
  - gap_cnt is sized $clog2(MAX_GAP+1)+1 bits and never wraps.
- A COMMA arriving on the same word that gap_cnt would overflow is a comma: lock is kept and the counter clears.
- Reset mid-LOCKED: immediate return to the reset values. Relock needs LOCK_COUNT fresh commas.
- COMMA and IDLE are matched exactly (8-bit compare). No disparity or error checking is done.

Decomposition:
- Shared package phy_pkg holds:
  - COMMA and IDLE symbol constants, which the TX side also uses.
  - State encoding: SEARCH=1'b0, LOCKED=1'b1.
- No sub-module is needed. Counters and FSM stay in a single always block plus an output register block.

Test Plan:
- Reset, then 4 valid 8'hBC -> active=1 on the cycle after the 4th BC sample, lane_ptr=0, valid_out stays 0 throughout.
- BC,BC,BC,8'h55,BC,BC,BC,BC -> active stays 0 through the 8'h55 and rises only after the final BC; comma_cnt is cleared by the 8'h55.
- Locked, send 8'h01..8'h06 back-to-back -> valid_out each cycle.
  - lane_sel sequence 0,1,2,3,0,1.
  - data_out equals each input one cycle later.
- Locked, send 8'h11, IDLE, 8'h22, BC, 8'h33:
  - lane_sel for 8'h11=0, 8'h22=1, 8'h33=0.
  - valid_out=0 on the IDLE and BC cycles.
- Locked, send MAX_GAP+1 non-comma words without a BC:
  - lock_loss pulses once and active drops.
  - The overflowing word is not forwarded.
  - 4 further BCs relock.
- Locked with valid_in toggling 1,0,1, plus reset asserted mid-stream:
  - Gaps cause no pointer advance.
  - Reset drops active and valid_out asynchronously.
  - After release, data without commas is never forwarded.
